// File: rtl/sfp_norm_seq.sv
// Normalization sequencer: loads N elements, sums them, then issues one
// divide (element << FRAC) / sum per element and streams the quotients out.
module sfp_norm_seq #(
  parameter int N    = 8,
  parameter int FRAC = 8,
  parameter int W    = 20,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             div_strt_pulse,
  input  logic             div_busy,
  input  logic             div_valid,
  output logic [W-1:0]     div_div,
  output logic [W-1:0]     div_dis,
  input  logic [W-1:0]     div_ans,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  input  logic             out_ready,
  output logic             ovf
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  // Shift headroom covers the largest supported FRAC.
  localparam int          XW    = W + 12;
  localparam logic [W-1:0] SAT  = '1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [W-1:0]            sum_q, sum_d;
  logic [N-1:0][W-1:0]     elem_q, elem_d;
  logic                    ovf_q, ovf_d;
  logic [W-1:0]            dd_q, dd_d;
  logic [W-1:0]            ds_q, ds_d;
  logic                    strt_q, strt_d;
  logic [W-1:0]            res_q, res_d;

  logic [W:0]              sum_ext;
  logic [W-1:0]            cur;
  logic [XW-1:0]           wide;
  logic                    scl_ovf;
  logic                    unused_busy;

  assign unused_busy = div_busy;

  assign sum_ext = {1'b0, sum_q} + {1'b0, in_data};
  assign cur     = elem_q[idx_q];
  assign wide    = XW'(cur) << FRAC;
  assign scl_ovf = |wide[XW-1:W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    elem_d  = elem_q;
    ovf_d   = ovf_q;
    dd_d    = dd_q;
    ds_d    = ds_q;
    strt_d  = 1'b0;
    res_d   = res_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          elem_d[cnt_q] = in_data;
          if (sum_ext[W]) begin
            sum_d = SAT;
            ovf_d = 1'b1;
          end else begin
            sum_d = sum_ext[W-1:0];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_ISSUE;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      S_ISSUE: begin
        // A zero divisor skips the divider and reports a zero quotient.
        if (sum_q == '0) begin
          res_d   = '0;
          state_d = S_OUT;
        end else begin
          dd_d = scl_ovf ? SAT : wide[W-1:0];
          if (scl_ovf) ovf_d = 1'b1;
          ds_d    = sum_q;
          strt_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (div_valid) begin
          res_d   = div_ans;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (idx_q == LAST) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            sum_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      elem_q  <= '0;
      ovf_q   <= 1'b0;
      dd_q    <= '0;
      ds_q    <= '0;
      strt_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      elem_q  <= elem_d;
      ovf_q   <= ovf_d;
      dd_q    <= dd_d;
      ds_q    <= ds_d;
      strt_q  <= strt_d;
      res_q   <= res_d;
    end
  end

  assign in_ready       = (state_q == S_LOAD);
  assign div_strt_pulse = strt_q;
  assign div_div        = dd_q;
  assign div_dis        = ds_q;
  assign out_valid      = (state_q == S_OUT);
  assign out_data       = res_q;
  assign out_idx        = idx_q;
  assign out_last       = (state_q == S_OUT) && (idx_q == LAST);
  assign ovf            = ovf_q;

endmodule
